// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM control path: FSM states,
// instruction-class opcodes, ALU commands, datapath mux selects and
// condition codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // instruction[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // alu_ctl
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // result_src
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // alu_src_b
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Data-processing cmd field, funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes, instruction[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register and per-instruction condition latch. The condition is
// evaluated against the registered flags while the FSM sits in DECODE and is
// frozen for the remainder of the instruction, so an instruction's own flag
// update never changes whether its writeback happens.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       cond_latch,
    input  logic [1:0] flag_w,
    output logic [3:0] flags,
    output logic       cond_ex_q
);

    logic [3:0] flags_q;
    logic       cond_ex;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Evaluate the ARM condition field against the current flags.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_f;
            COND_NE: cond_ex = ~z_f;
            COND_CS: cond_ex = c_f;
            COND_CC: cond_ex = ~c_f;
            COND_MI: cond_ex = n_f;
            COND_PL: cond_ex = ~n_f;
            COND_VS: cond_ex = v_f;
            COND_VC: cond_ex = ~v_f;
            COND_HI: cond_ex = c_f & ~z_f;
            COND_LS: cond_ex = ~c_f | z_f;
            COND_GE: cond_ex = (n_f == v_f);
            COND_LT: cond_ex = (n_f != v_f);
            COND_GT: cond_ex = ~z_f & (n_f == v_f);
            COND_LE: cond_ex = z_f | (n_f != v_f);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Latch the condition at the end of DECODE; update NZ / CV when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            if (cond_latch) begin
                cond_ex_q <= cond_ex;
            end
            if (flag_w[1] && cond_ex_q) begin
                flags_q[3:2] <= alu_flags[3:2];
            end
            if (flag_w[0] && cond_ex_q) begin
                flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle ARM datapath. Steps each instruction through
// fetch, decode and its class-specific execute/memory/writeback states, drives
// the shared-datapath mux selects and write strobes, and decodes the ALU
// command and flag-write enables. Write strobes are held low during reset so
// an instruction interrupted by reset leaves no further side effects.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    output logic       pc_w,
    output logic       ir_w,
    output logic       reg_w,
    output logic       mem_w,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [1:0] alu_ctl,
    output logic [3:0] flags
);

    state_t     state_q;
    state_t     state_d;
    logic       cond_ex_q;
    logic       cond_latch;
    logic [1:0] flag_w;
    logic [1:0] dp_ctl;
    logic       no_write;
    logic       rd_is_pc;
    logic       pc_w_raw, ir_w_raw, reg_w_raw, mem_w_raw;

    assign rd_is_pc = (rd == 4'd15);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection by instruction class.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Data-processing ALU command decode; unsupported commands add and discard.
    always_comb begin
        dp_ctl   = ALU_ADD;
        no_write = 1'b0;
        case (funct[4:1])
            CMD_ADD: dp_ctl = ALU_ADD;
            CMD_SUB: dp_ctl = ALU_SUB;
            CMD_AND: dp_ctl = ALU_AND;
            CMD_ORR: dp_ctl = ALU_ORR;
            CMD_CMP: begin
                dp_ctl   = ALU_SUB;
                no_write = 1'b1;
            end
            default: begin
                dp_ctl   = ALU_ADD;
                no_write = 1'b1;
            end
        endcase
    end

    // Per-state datapath controls and ungated write strobes.
    always_comb begin
        pc_w_raw   = 1'b0;
        ir_w_raw   = 1'b0;
        reg_w_raw  = 1'b0;
        mem_w_raw  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_WD;
        result_src = RES_ALUOUT;
        alu_ctl    = ALU_ADD;
        cond_latch = 1'b0;
        flag_w     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_w_raw   = 1'b1;
                pc_w_raw   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                cond_latch = 1'b1;
            end
            S_MEMADR: begin
                alu_src_b = SRCB_IMM;
                alu_ctl   = funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_w_raw = cond_ex_q;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w_raw  = cond_ex_q;
                pc_w_raw   = cond_ex_q & rd_is_pc;
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_src_b = (state_q == S_EXECUTEI) ? SRCB_IMM : SRCB_WD;
                alu_ctl   = dp_ctl;
                flag_w[1] = funct[0];
                flag_w[0] = funct[0] & ((dp_ctl == ALU_ADD) | (dp_ctl == ALU_SUB));
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_w_raw  = cond_ex_q & ~no_write;
                pc_w_raw   = cond_ex_q & ~no_write & rd_is_pc;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_w_raw   = cond_ex_q;
            end
            default: begin
                pc_w_raw = 1'b0;
            end
        endcase
    end

    // Strobes are suppressed for as long as reset is held.
    assign pc_w  = pc_w_raw  & rst_n;
    assign ir_w  = ir_w_raw  & rst_n;
    assign reg_w = reg_w_raw & rst_n;
    assign mem_w = mem_w_raw & rst_n;

    assign imm_src = op;
    assign reg_src = {(op == OP_MEM), (op == OP_BR)};

    cond_unit u_cond_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .cond       (cond),
        .alu_flags  (alu_flags),
        .cond_latch (cond_latch),
        .flag_w     (flag_w),
        .flags      (flags),
        .cond_ex_q  (cond_ex_q)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. For each instruction the
// reference model precomputes the whole per-cycle output sequence from the
// instruction class, the condition outcome and the flags, then the bench
// steps the DUT and compares every cycle.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       pc_w, ir_w, reg_w, mem_w, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, reg_src, alu_ctl;
    logic [3:0] flags;

    int check_cnt = 0;
    int err_cnt   = 0;

    logic [19:0] exp_q[$];
    logic [3:0]  m_flags;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cond       (cond),
        .op         (op),
        .funct      (funct),
        .rd         (rd),
        .alu_flags  (alu_flags),
        .pc_w       (pc_w),
        .ir_w       (ir_w),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .reg_src    (reg_src),
        .alu_ctl    (alu_ctl),
        .flags      (flags)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

    wire [19:0] dut_vec = {pc_w, ir_w, reg_w, mem_w, adr_src, alu_src_a,
                           alu_src_b, result_src, imm_src, reg_src, alu_ctl, flags};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected output vector; imm_src/reg_src follow the op currently driven.
    function automatic logic [19:0] mk(input logic pcw, input logic irw, input logic rw,
                                       input logic mw, input logic as, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] rs,
                                       input logic [1:0] ctl, input logic [3:0] fl);
        logic [1:0] rsrc;
        rsrc = {(op == 2'b01), (op == 2'b10)};
        return {pcw, irw, rw, mw, as, asa, asb, rs, op, rsrc, ctl, fl};
    endfunction

    // Build the full expected cycle sequence for the instruction on the inputs.
    task automatic build_expect(input logic [3:0] af);
        bit         e, writes, arith;
        logic [1:0] ctl;
        logic [3:0] f1;
        e  = cond_pass(cond, m_flags);
        f1 = m_flags;
        exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, m_flags));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, m_flags));
        if (op == 2'b01) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00,
                               funct[3] ? 2'b00 : 2'b01, m_flags));
            if (funct[0]) begin
                exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, m_flags));
                exp_q.push_back(mk(e && rd == 15, 0, e, 0, 0, 0, 2'b00, 2'b01, 2'b00, m_flags));
            end else begin
                exp_q.push_back(mk(0, 0, 0, e, 1, 0, 2'b00, 2'b00, 2'b00, m_flags));
            end
        end else if (op == 2'b00) begin
            writes = 1;
            case (funct[4:1])
                4'b0100: ctl = 2'b00;
                4'b0010: ctl = 2'b01;
                4'b0000: ctl = 2'b10;
                4'b1100: ctl = 2'b11;
                4'b1010: begin ctl = 2'b01; writes = 0; end
                default: begin ctl = 2'b00; writes = 0; end
            endcase
            arith = (ctl == 2'b00) || (ctl == 2'b01);
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, funct[5] ? 2'b01 : 2'b00, 2'b00, ctl, m_flags));
            if (e && funct[0]) begin
                f1[3:2] = af[3:2];
                if (arith) f1[1:0] = af[1:0];
            end
            exp_q.push_back(mk(e && writes && rd == 15, 0, e && writes, 0, 0, 0,
                               2'b00, 2'b00, 2'b00, f1));
        end else if (op == 2'b10) begin
            exp_q.push_back(mk(e, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, m_flags));
        end
        m_flags = f1;
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r, input logic [3:0] af);
        int k;
        logic [19:0] exp;
        cond = c; op = o; funct = f; rd = r; alu_flags = af;
        build_expect(af);
        k = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            #1;
            check($sformatf("%s cyc%0d", name, k), 32'(dut_vec), 32'(exp));
            @(negedge clk);
            k++;
        end
    endtask

    task automatic reset_vec_check(input string name);
        #1;
        check(name, 32'(dut_vec), 32'(mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 4'h0)));
    endtask

    initial begin
        logic [19:0] exp;
        rst_n = 1'b0; cond = 4'hE; op = 2'b00; funct = 6'h0; rd = 4'h0; alu_flags = 4'h0;
        m_flags = 4'h0;
        @(negedge clk);
        reset_vec_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // directed
        run_instr("add",     4'hE, 2'b00, 6'b001000, 4'd1,  4'hF);
        run_instr("ldr",     4'hE, 2'b01, 6'b011001, 4'd2,  4'h0);
        run_instr("ldr_pc",  4'hE, 2'b01, 6'b011001, 4'd15, 4'h0);
        run_instr("str",     4'hE, 2'b01, 6'b011000, 4'd3,  4'h0);
        run_instr("cmp",     4'hE, 2'b00, 6'b010101, 4'd0,  4'b0100);
        run_instr("beq",     4'h0, 2'b10, 6'b000000, 4'd0,  4'h0);
        run_instr("bne",     4'h1, 2'b10, 6'b000000, 4'd0,  4'h0);
        run_instr("adds_z0", 4'hE, 2'b00, 6'b001001, 4'd4,  4'b0000);
        run_instr("subs_eq", 4'h0, 2'b00, 6'b000101, 4'd5,  4'b0100);
        run_instr("nv",      4'hF, 2'b00, 6'b101001, 4'd15, 4'hF);
        run_instr("op11",    4'hE, 2'b11, 6'b111111, 4'd15, 4'hF);
        run_instr("ldr_sub", 4'hE, 2'b01, 6'b010001, 4'd15, 4'h0);
        run_instr("orr_pc",  4'hE, 2'b00, 6'b111000, 4'd15, 4'h0);

        // random
        for (int i = 0; i < 300; i++) begin
            run_instr($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), 6'($urandom),
                      ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14)),
                      4'($urandom));
        end

        // reset in the middle of a store
        run_instr("adds_all", 4'hE, 2'b00, 6'b001001, 4'd6, 4'hF);
        cond = 4'hE; op = 2'b01; funct = 6'b011000; rd = 4'd7; alu_flags = 4'h0;
        build_expect(4'h0);
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            #1;
            check($sformatf("rst_str cyc%0d", k), 32'(dut_vec), 32'(exp));
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        #1;
        check("rst_str memwrite", 32'(dut_vec), 32'(exp));
        rst_n = 1'b0;
        exp_q.delete();
        m_flags = 4'h0;
        #1;
        check("rst_str mem_w_drop", 32'(mem_w), 32'(1'b0));
        reset_vec_check("rst_str in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_instr("post_rst", 4'hE, 2'b00, 6'b001000, 4'd1, 4'h0);
        run_instr("post_rst_b", 4'hE, 2'b10, 6'b000000, 4'd0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle ARM datapath. One instruction executes over 3-5 cycles, and the memory, ALU and register file are shared across those cycles.
- Sequences instruction fetch, decode, address generation, memory access, ALU execute and writeback.
- Owns the NZCV flag register and condition evaluation.
- Decodes the ALU command and flag-write enables per instruction.

Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cond  in  4  instruction[31:28]
- op  in  2  instruction[27:26]
- funct  in  6  instruction[25:20]
- rd  in  4  instruction[15:12]
- alu_flags  in  4  NZCV from the ALU in the current cycle
- pc_w  out  1  PC write enable
- ir_w  out  1  instruction register write enable
- reg_w  out  1  register file write enable
- mem_w  out  1  data memory write enable
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut register
- alu_src_a  out  1  ALU A operand: 0 = A register, 1 = PC
- alu_src_b  out  2  ALU B operand: 00 = WriteData register, 01 = ExtImm, 10 = constant 4
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data register, 10 = ALU result
- imm_src  out  2  extend control, equal to op
- reg_src  out  2  [0] = RA1 uses R15 (branch); [1] = RA2 uses rd (STR)
- alu_ctl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- flags  out  4  registered NZCV

Behaviour:
- Reset: state = FETCH, flags = 0, cond_ex_q = 0. While rst_n is low, all write strobes (pc_w, ir_w, reg_w, mem_w) are forced to 0. Reset mid-instruction aborts the instruction with no further writes.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - op = 01 -> MEMADR.
    - op = 00 with funct[5] = 0 -> EXECUTER; with funct[5] = 1 -> EXECUTEI.
    - op = 10 -> BRANCH.
    - op = 11 -> FETCH; no side effects.
  - MEMADR: funct[0] = 1 (LDR) -> MEMREAD, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER / EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Latency: B = 3 cycles; data-processing and STR = 4; LDR = 5.
- Per-state outputs (unlisted outputs = 0):
  - FETCH: adr_src=0, ir_w=1, alu_src_a=1, alu_src_b=10, alu_ctl=ADD, result_src=10, pc_w=1.
  - DECODE: alu_src_a=1, alu_src_b=10, alu_ctl=ADD, result_src=10 (R15 reads PC+8).
  - MEMADR: alu_src_a=0, alu_src_b=01, alu_ctl = ADD if funct[3] (U bit) else SUB.
  - MEMREAD: adr_src=1.
  - MEMWRITE: adr_src=1, mem_w=cond_ex_q.
  - MEMWB: result_src=01, reg_w=cond_ex_q, pc_w = cond_ex_q & (rd==15).
  - EXECUTER: alu_src_a=0, alu_src_b=00, alu_ctl from cmd.
  - EXECUTEI: same as EXECUTER but alu_src_b=01.
  - ALUWB: result_src=00, reg_w = cond_ex_q & !no_write, pc_w = cond_ex_q & !no_write & (rd==15).
  - BRANCH: alu_src_a=0, alu_src_b=01, alu_ctl=ADD, result_src=10, pc_w=cond_ex_q.
- imm_src and reg_src are combinational from op in every state.
- ALU decode, cmd = funct[4:1]:
  - 0100 -> ADD; 0010 -> SUB; 0000 -> AND; 1100 -> ORR.
  - 1010 (CMP) -> SUB with no_write=1.
  - Any other cmd -> ADD with no_write=1.
- Flag write, applied only at the end of EXECUTER/EXECUTEI, gated by cond_ex_q and funct[0] (S):
  - flag_w[1] = S; updates N and Z from alu_flags.
  - flag_w[0] = S & (alu_ctl is ADD or SUB); updates C and V.
  - CMP always has S set.
- Condition evaluation:
  - cond_ex is evaluated in DECODE from cond and the registered flags, then latched into cond_ex_q at the end of DECODE. It holds for the rest of the instruction, so a flag update in EXECUTE does not affect that instruction's own writeback.
  - Codes EQ..AL (0000-1110) follow the standard ARM definitions; 1111 -> not executed.
- A not-executed instruction still walks all its states and updates the PC in FETCH; it produces no reg_w, mem_w, flag or branch writes.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum;
  - op encodings (OP_DP = 00, OP_MEM = 01, OP_BR = 10);
  - alu_ctl encodings;
  - result_src and alu_src_b encodings;
  - cond code constants.
- Sub-module cond_unit holds the flag register, flag_w gating and the cond_ex_q latch. The FSM and ALU decode stay in multicycle_controller.

Test Plan:
- ADD R1,R2,R3 (cond=1110, op=00, funct=001000): FETCH, DECODE, EXECUTER, ALUWB, FETCH; reg_w=1 only in ALUWB; alu_ctl=00; flags unchanged.
- LDR (op=01, funct=011001): 5-cycle sequence; adr_src=1 in MEMREAD; result_src=01 and reg_w=1 in MEMWB. Same with rd=15: pc_w=1 in MEMWB.
- STR (funct=011000): mem_w=1 for exactly one cycle in MEMWRITE; reg_w stays 0 throughout.
- CMP (funct=010101) with alu_flags=0100 -> flags=0100 after EXECUTER, reg_w=0 in ALUWB. Then BEQ (cond=0000, op=10) -> pc_w=1 in BRANCH. BNE (cond=0001) -> pc_w=0 in BRANCH.
- SUBS whose own result sets Z, with cond=EQ and Z=0 beforehand: not executed; flags and reg_w unaffected.
- rst_n asserted during MEMWRITE: mem_w drops to 0 immediately, flags=0, and the FSM restarts in FETCH after release.
